conv_idx_seq: RTL
=================

// Module: conv_idx_seq
// PURPOSE
//  Reads the full-size convolution length (sizex+sizey-1) produced by the size register and walks it.
//  For each output index k it issues every valid (x,y) operand address pair to the MAC datapath.
//  It then issues one result write, so it is the consumer side of the size-register interface.
//  Sits between the control FSM (start/done) and the X/Y/Z memories plus MAC.
// PARAMETERS
//  none (widths fixed: sizes 5 b, full size 6 b)
// PORTS
//  clk          in   1  system clock, posedge
//  rst          in   1  asynchronous, active-high reset
//  start_i      in   1  1-cycle request to sequence one convolution
//  sizex_i      in   5  length of X vector
//  sizey_i      in   5  length of Y vector
//  size_full_i  in   6  full-size length from size register
//  ready_i      in   1  MAC accepts current operand pair
//  valid_o      out  1  memx_addr_o/memy_addr_o hold a valid pair
//  memx_addr_o  out  5  X address = k-j
//  memy_addr_o  out  5  Y address = j
//  first_o      out  1  with valid_o: first pair of this k (MAC clears accumulator)
//  z_wr_o       out  1  1-cycle write strobe of accumulated result
//  memz_addr_o  out  6  Z address = k
//  busy_o       out  1  sequence in progress
//  done_o       out  1  1-cycle pulse at end (normal or error)
//  err_o        out  1  sticky until next accepted start; size_full_i mismatch
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; all outputs 0, internal k/j/sizes 0.
//  FSM states: IDLE, LOAD, SCAN, WRITE, DONE.
//  IDLE: busy_o=0. start_i=1 -> latch sizex_i, sizey_i, size_full_i; clear err_o; go LOAD.
//  LOAD (1 cycle, busy_o=1): compute chk = sizex+sizey-1 in 6 b.
//   - if sizex==0 or sizey==0 -> DONE, no pairs, no writes, err_o stays 0.
//   - else if size_full != chk -> err_o=1, go DONE.
//   - else k=0, j=jmin(0), go SCAN.
//  jmin(k) = max(0, k-(sx-1)); jmax(k) = min(k, sy-1); compute in 6 b, no wrap.
//  SCAN: valid_o=1, memx_addr_o=k-j, memy_addr_o=j, first_o=(j==jmin(k)).
//   - Outputs are held stable while ready_i=0.
//   - Pair is accepted on valid_o&&ready_i.
//   - Accept with j<jmax: j++ next cycle.
//   - Accept with j==jmax: go WRITE.
//  WRITE (1 cycle): valid_o=0, z_wr_o=1, memz_addr_o=k.
//   - if k==size_full-1 -> DONE.
//   - else k++, j=jmin(k+1), go SCAN.
//  DONE (1 cycle): done_o=1, busy_o=0, then IDLE.
//  All outputs are registered; valid_o rises the cycle after LOAD.
//  start_i outside IDLE is ignored (no restart, no queueing).
//  Total pairs = sx*sy; total writes = size_full.
//  Cycles with ready_i always 1: 1 (LOAD) + sx*sy + size_full + 1 (DONE).
//  Max sizes 31x31 -> size_full=61 fits 6 b; k-j never negative.
//  rst asserted mid-sequence: immediate return to IDLE, all outputs 0, no done_o.
// TESTING
//  1. sx=3,sy=2,full=4, ready=1 -> pairs(x,y): (0,0)*,(1,0)*,(0,1),(2,0)*,(1,1),(2,1)*
//     (* = first_o); z_wr at k=0..3; done_o 12 cycles after start.
//  2. Same as 1 with ready_i=0 for 3 cycles on the 2nd pair -> addr (1,0) held, no extra pairs,
//     done delayed by exactly 3 cycles.
//  3. sx=1,sy=1,full=1 -> one pair (0,0) first_o=1, one z_wr addr 0, done_o; err_o=0.
//  4. sx=4,sy=3,full=5 (wrong) -> no valid_o, no z_wr, err_o=1 and done_o in cycle after LOAD.
//  5. sx=0,sy=5 -> done_o after LOAD, zero pairs/writes, err_o=0.
//     start_i pulsed while busy in test 1 -> ignored.
//  6. sx=31,sy=31,full=61 -> 961 pairs, 61 writes, last pair (30,30) at memz_addr 60.
//     rst pulsed at pair 100 -> outputs 0 asynchronously, next start runs cleanly.

Source files
------------

// File: rtl/conv_idx_seq.sv
// Convolution index sequencer: walks output index k over the full-size length and
// issues every (x,y) operand address pair to the MAC, then one Z result write per k.
module conv_idx_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic [4:0] sizex_i,
   input  logic [4:0] sizey_i,
   input  logic [5:0] size_full_i,
   input  logic       ready_i,
   output logic       valid_o,
   output logic [4:0] memx_addr_o,
   output logic [4:0] memy_addr_o,
   output logic       first_o,
   output logic       z_wr_o,
   output logic [5:0] memz_addr_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o
);

   typedef enum logic [2:0] {IDLE, LOAD, SCAN, WRITE, DONE} state_t;

   state_t     state, state_n;
   logic [4:0] sx, sx_n, sy, sy_n;
   logic [5:0] sf, sf_n;
   logic [5:0] k, k_n, j, j_n;
   logic       err_n;
   logic [5:0] chk;
   logic [5:0] diff_n;

   logic       valid_n, first_n, z_wr_n, busy_n, done_n;
   logic [4:0] memx_n, memy_n;
   logic [5:0] memz_n;

   // Lowest y index contributing to output k: max(0, k-(sx-1)), never wraps.
   function automatic logic [5:0] jmin_f(input logic [5:0] kk, input logic [4:0] s);
      logic [5:0] sm1;
      sm1 = {1'b0, s} - 6'd1;
      return (kk > sm1) ? (kk - sm1) : 6'd0;
   endfunction

   // Highest y index contributing to output k: min(k, sy-1).
   function automatic logic [5:0] jmax_f(input logic [5:0] kk, input logic [4:0] s);
      logic [5:0] sm1;
      sm1 = {1'b0, s} - 6'd1;
      return (kk < sm1) ? kk : sm1;
   endfunction

   assign chk = {1'b0, sx} + {1'b0, sy} - 6'd1;

   always_comb begin
      state_n = state;
      sx_n    = sx;
      sy_n    = sy;
      sf_n    = sf;
      k_n     = k;
      j_n     = j;
      err_n   = err_o;

      unique case (state)
         IDLE: begin
            if (start_i) begin
               sx_n    = sizex_i;
               sy_n    = sizey_i;
               sf_n    = size_full_i;
               err_n   = 1'b0;
               state_n = LOAD;
            end
         end
         LOAD: begin
            if (sx == 5'd0 || sy == 5'd0) begin
               state_n = DONE;
            end else if (sf != chk) begin
               err_n   = 1'b1;
               state_n = DONE;
            end else begin
               k_n     = 6'd0;
               j_n     = 6'd0;
               state_n = SCAN;
            end
         end
         SCAN: begin
            if (valid_o && ready_i) begin
               if (j == jmax_f(k, sy)) state_n = WRITE;
               else                    j_n     = j + 6'd1;
            end
         end
         WRITE: begin
            if (k == sf - 6'd1) begin
               state_n = DONE;
            end else begin
               k_n     = k + 6'd1;
               j_n     = jmin_f(k + 6'd1, sx);
               state_n = SCAN;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // Outputs are derived from the next state so they come straight out of flops;
      // while stalled k/j are unchanged, so the pair presented stays stable.
      diff_n  = k_n - j_n;
      valid_n = (state_n == SCAN);
      memx_n  = valid_n ? diff_n[4:0] : 5'd0;
      memy_n  = valid_n ? j_n[4:0] : 5'd0;
      first_n = valid_n && (j_n == jmin_f(k_n, sx_n));
      z_wr_n  = (state_n == WRITE);
      memz_n  = z_wr_n ? k_n : 6'd0;
      busy_n  = (state_n == LOAD) || (state_n == SCAN) || (state_n == WRITE);
      done_n  = (state_n == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         sx          <= '0;
         sy          <= '0;
         sf          <= '0;
         k           <= '0;
         j           <= '0;
         err_o       <= 1'b0;
         valid_o     <= 1'b0;
         memx_addr_o <= '0;
         memy_addr_o <= '0;
         first_o     <= 1'b0;
         z_wr_o      <= 1'b0;
         memz_addr_o <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         state       <= state_n;
         sx          <= sx_n;
         sy          <= sy_n;
         sf          <= sf_n;
         k           <= k_n;
         j           <= j_n;
         err_o       <= err_n;
         valid_o     <= valid_n;
         memx_addr_o <= memx_n;
         memy_addr_o <= memy_n;
         first_o     <= first_n;
         z_wr_o      <= z_wr_n;
         memz_addr_o <= memz_n;
         busy_o      <= busy_n;
         done_o      <= done_n;
      end
   end

endmodule
